// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encodings for the bit-serial subtractor
package serial_subtractor_pkg;

   // FSM encodings; 2'd3 is unused and recovers to IDLE
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // borrow out when x < y + bin for this bit position
   always_comb begin
      diff = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor d = a - b - b_in with start/done handshake
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             busy,
   output logic             done
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             cell_diff;
   logic             cell_bout;

   full_subtractor u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (brw),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // FSM, operand shifters, bit counter and the result register that d mirrors only at completion
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         d      <= '0;
         b_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  brw    <= b_in;
                  res_sh <= '0;
                  cnt    <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh <= {cell_diff, res_sh[WIDTH-1:1]};
               brw    <= cell_bout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  // last bit: publish the completed word and final borrow together
                  d     <= {cell_diff, res_sh[WIDTH-1:1]};
                  b_out <= cell_bout;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // status flags decode straight from the state register
   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

endmodule
